// File: rtl/player_cnt_writer_pkg.sv
// Shared types and constants for the player count writer.
// Holds the FSM state encoding, count width and player-count codes.
package player_cnt_writer_pkg;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned NUM_P = 4;

  localparam logic [1:0] N_2P = 2'b00;
  localparam logic [1:0] N_3P = 2'b01;
  localparam logic [1:0] N_4P = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_STEP,
    ST_UPDATE,
    ST_ADVANCE,
    ST_DONE
  } state_e;

  // Index of the last active player; code 11 behaves like 4 players.
  function automatic logic [1:0] last_player(input logic [1:0] n);
    case (n)
      N_2P:    return 2'd1;
      N_3P:    return 2'd2;
      N_4P:    return 2'd3;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/player_turn_ctr.sv
// Turn counter: holds the current player index T and the latched player-count code.
// T wraps to 0 after the last active player for the latched code.
module player_turn_ctr
  import player_cnt_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [1:0] n_i,
  input  logic       advance_i,
  output logic [1:0] t_o,
  output logic [1:0] last_o
);

  logic [1:0] t_q, t_d;
  logic [1:0] n_q, n_d;

  always_comb begin
    t_d = t_q;
    n_d = n_q;
    if (load_i) begin
      n_d = n_i;
      t_d = '0;
    end else if (advance_i) begin
      t_d = (t_q == last_player(n_q)) ? 2'd0 : t_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q <= '0;
      n_q <= N_2P;
    end else begin
      t_q <= t_d;
      n_q <= n_d;
    end
  end

  assign t_o    = t_q;
  assign last_o = last_player(n_q);

endmodule

// File: rtl/player_cnt_writer.sv
// Board-game position tracker: per-player counts advanced by accepted steps, saturating at TARGET.
// Optional macro CAPTURE_EN: the mover landing on another active player's count sends that player to 0.
module player_cnt_writer
  import player_cnt_writer_pkg::*;
#(
  parameter int unsigned TARGET = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       N,
  input  logic             step_valid,
  input  logic [2:0]       step,
  output logic             step_ready,
  output logic [1:0]       T,
  output logic [CNT_W-1:0] p1_cnt,
  output logic [CNT_W-1:0] p2_cnt,
  output logic [CNT_W-1:0] p3_cnt,
  output logic [CNT_W-1:0] p4_cnt,
  output logic             done,
  output logic [1:0]       winner
);

  localparam logic [CNT_W:0]   TGT6 = (CNT_W+1)'(TARGET);
  localparam logic [CNT_W-1:0] TGT5 = CNT_W'(TARGET);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_P];
  logic [CNT_W-1:0] cnt_d [NUM_P];
  logic [2:0]       step_q, step_d;
  logic [1:0]       winner_q, winner_d;

  logic             load;
  logic             advance;
  logic [1:0]       t;
  logic [1:0]       last;
  logic [CNT_W:0]   sum6;
  logic [CNT_W-1:0] new_cnt;

  player_turn_ctr u_turn (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .n_i       (N),
    .advance_i (advance),
    .t_o       (t),
    .last_o    (last)
  );

  // Sum at one extra bit so a large step cannot wrap past TARGET.
  assign sum6    = {1'b0, cnt_q[t]} + {{(CNT_W-2){1'b0}}, step_q};
  assign new_cnt = (sum6 >= TGT6) ? TGT5 : sum6[CNT_W-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    winner_d = winner_q;
    load     = 1'b0;
    advance  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '{default: '0};
          state_d = ST_WAIT_STEP;
        end
      end
      ST_WAIT_STEP: begin
        if (step_valid) begin
          step_d  = step;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        // The mover is always active; the guard keeps inactive slots provably at zero.
        if (t <= last) begin
          cnt_d[t] = new_cnt;
        end
`ifdef CAPTURE_EN
        for (int unsigned i = 0; i < NUM_P; i++) begin
          if ((2'(i) != t) && (2'(i) <= last) && (cnt_q[i] == new_cnt) &&
              (new_cnt != '0) && (new_cnt != TGT5)) begin
            cnt_d[i] = '0;
          end
        end
`endif
        if (new_cnt == TGT5) begin
          winner_d = t;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        advance = 1'b1;
        state_d = ST_WAIT_STEP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '{default: '0};
      step_q   <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      winner_q <= winner_d;
    end
  end

  assign step_ready = (state_q == ST_WAIT_STEP);
  assign done       = (state_q == ST_DONE);
  assign winner     = winner_q;
  assign T          = t;
  assign p1_cnt     = cnt_q[0];
  assign p2_cnt     = cnt_q[1];
  assign p3_cnt     = cnt_q[2];
  assign p4_cnt     = cnt_q[3];

endmodule

// File: tb/tb_player_cnt_writer.sv
// Directed bench for player_cnt_writer (TARGET = 24); capture expectations follow CAPTURE_EN.
module tb_player_cnt_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] N;
  logic       step_valid;
  logic [2:0] step;
  logic       step_ready;
  logic [1:0] T;
  logic [4:0] p1_cnt, p2_cnt, p3_cnt, p4_cnt;
  logic       done;
  logic [1:0] winner;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  player_cnt_writer #(.TARGET(24)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .N          (N),
    .step_valid (step_valid),
    .step       (step),
    .step_ready (step_ready),
    .T          (T),
    .p1_cnt     (p1_cnt),
    .p2_cnt     (p2_cnt),
    .p3_cnt     (p3_cnt),
    .p4_cnt     (p4_cnt),
    .done       (done),
    .winner     (winner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (step_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(step_ready), 32'd1);
  endtask

  // Returns at the negedge inside UPDATE.
  task automatic handshake(input logic [2:0] s);
    wait_ready();
    step_valid = 1'b1;
    step       = s;
    @(negedge clk);
    step_valid = 1'b0;
  endtask

  task automatic play(input logic [2:0] s);
    handshake(s);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] n);
    @(negedge clk);
    start = 1'b1;
    N     = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; N = 2'b00; step_valid = 1'b0; step = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(step_ready), 32'd0);
    check("rst_T", 32'(T), 32'd0);
    check("rst_p1", 32'(p1_cnt), 32'd0);
    check("rst_p4", 32'(p4_cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(step_ready), 32'd0);

    // Two players: 3 then 5.
    pulse_start(2'b00);
    check("2p_start_T", 32'(T), 32'd0);
    check("2p_start_ready", 32'(step_ready), 32'd1);
    handshake(3'd3);
    check("2p_update_ready", 32'(step_ready), 32'd0);
    @(negedge clk);
    check("2p_p1_after_update", 32'(p1_cnt), 32'd3);
    check("2p_T_before_adv", 32'(T), 32'd0);
    @(negedge clk);
    check("2p_T_adv", 32'(T), 32'd1);
    check("2p_ready_again", 32'(step_ready), 32'd1);
    play(3'd5);
    check("2p_p2", 32'(p2_cnt), 32'd5);
    check("2p_T_wrap", 32'(T), 32'd0);
    check("2p_p3", 32'(p3_cnt), 32'd0);
    check("2p_p4", 32'(p4_cnt), 32'd0);

    // Four players, four steps of 2.
    do_reset();
    pulse_start(2'b10);
    for (int i = 0; i < 4; i++) begin
      check("4p_T_seq", 32'(T), 32'(i));
      play(3'd2);
    end
    check("4p_T_wrap", 32'(T), 32'd0);
    check("4p_p1", 32'(p1_cnt), 32'd2);
    check("4p_p2", 32'(p2_cnt), 32'd2);
    check("4p_p3", 32'(p3_cnt), 32'd2);
    check("4p_p4", 32'(p4_cnt), 32'd2);

    // Win with saturation: p1 reaches 22, then steps 7.
    do_reset();
    pulse_start(2'b00);
    play(3'd7); play(3'd0); play(3'd7); play(3'd0);
    play(3'd7); play(3'd0); play(3'd1); play(3'd0);
    check("win_p1_pre", 32'(p1_cnt), 32'd22);
    check("win_T_pre", 32'(T), 32'd0);
    handshake(3'd7);
    @(negedge clk);
    check("win_p1", 32'(p1_cnt), 32'd24);
    check("win_done", 32'(done), 32'd1);
    check("win_winner", 32'(winner), 32'd0);
    check("win_ready", 32'(step_ready), 32'd0);
    check("win_T", 32'(T), 32'd0);
    step_valid = 1'b1; step = 3'd5;
    repeat (3) @(negedge clk);
    step_valid = 1'b0;
    check("done_hold_p1", 32'(p1_cnt), 32'd24);
    check("done_hold_p2", 32'(p2_cnt), 32'd0);
    check("done_hold_done", 32'(done), 32'd1);
    check("done_hold_T", 32'(T), 32'd0);

    // Restart from DONE with three players.
    pulse_start(2'b01);
    check("restart_done", 32'(done), 32'd0);
    check("restart_p1", 32'(p1_cnt), 32'd0);
    check("restart_T", 32'(T), 32'd0);
    check("restart_ready", 32'(step_ready), 32'd1);

    // Step 0 for player 2 of 3, with a start pulse during UPDATE.
    play(3'd4);
    check("3p_p1", 32'(p1_cnt), 32'd4);
    check("3p_T1", 32'(T), 32'd1);
    handshake(3'd0);
    start = 1'b1; N = 2'b00;
    @(negedge clk);
    start = 1'b0;
    check("zero_p2", 32'(p2_cnt), 32'd0);
    check("zero_T_hold", 32'(T), 32'd1);
    check("ignstart_p1", 32'(p1_cnt), 32'd4);
    @(negedge clk);
    check("zero_T_adv", 32'(T), 32'd2);
    check("ignstart_ready", 32'(step_ready), 32'd1);
    play(3'd1);
    check("3p_p3", 32'(p3_cnt), 32'd1);
    check("3p_T_wrap", 32'(T), 32'd0);

    // Capture scenario: p2 at 6, p1 at 4 steps 2.
    play(3'd0);
    play(3'd6);
    check("cap_p2_pre", 32'(p2_cnt), 32'd6);
    play(3'd0);
    check("cap_T_pre", 32'(T), 32'd0);
    play(3'd2);
    check("cap_p1", 32'(p1_cnt), 32'd6);
`ifdef CAPTURE_EN
    check("cap_p2", 32'(p2_cnt), 32'd0);
`else
    check("cap_p2", 32'(p2_cnt), 32'd6);
`endif
    check("cap_p3", 32'(p3_cnt), 32'd1);
    check("cap_p4", 32'(p4_cnt), 32'd0);
    check("cap_T", 32'(T), 32'd1);

    // Reset the cycle after a handshake.
    handshake(3'd3);
    rst = 1'b1;
    #1;
    check("midrst_p1", 32'(p1_cnt), 32'd0);
    check("midrst_p2", 32'(p2_cnt), 32'd0);
    check("midrst_p3", 32'(p3_cnt), 32'd0);
    check("midrst_T", 32'(T), 32'd0);
    check("midrst_ready", 32'(step_ready), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_idle_ready", 32'(step_ready), 32'd0);
    check("postrst_p2", 32'(p2_cnt), 32'd0);
    pulse_start(2'b00);
    check("postrst_start_ready", 32'(step_ready), 32'd1);
    check("postrst_start_T", 32'(T), 32'd0);
    play(3'd5);
    check("postrst_p1", 32'(p1_cnt), 32'd5);
    check("postrst_T", 32'(T), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/player_cnt_writer.md
PLAYER_CNT_WRITER -- requirements
Module: player_cnt_writer

Interface
REQ-001 Parameter TARGET, default 24, meaning the finish count; legal range 1..31.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that begins a new game.
REQ-005 N  input  2  player-count code sampled on start: 00 = 2 players, 01 = 3 players, 10 = 4 players, 11 = treated as 10.
REQ-006 step_valid  input  1  a step value is offered.
REQ-007 step  input  3  number of positions to advance the current player (0..7).
REQ-008 step_ready  output  1  the block accepts a step this cycle.
REQ-009 T  output  2  index of the current player (0 = p1 .. 3 = p4).
REQ-010 p1_cnt, p2_cnt, p3_cnt, p4_cnt  output  5 each  player position counts.
REQ-011 done  output  1  the game has ended.
REQ-012 winner  output  2  index of the winning player; valid only while done = 1.

Function
REQ-013 The block SHALL implement the FSM IDLE -> WAIT_STEP -> UPDATE -> ADVANCE -> WAIT_STEP, with UPDATE -> DONE on a win and DONE -> WAIT_STEP on start.
REQ-014 In IDLE or DONE, a start pulse SHALL latch N, clear all four counts, set T = 0, and enter WAIT_STEP on the next cycle; done SHALL clear on the same edge.
REQ-015 step_ready SHALL be 1 only in WAIT_STEP, and a step SHALL transfer when step_valid and step_ready are both 1 on a rising edge.
REQ-016 UPDATE SHALL write cnt[T] = min(cnt[T] + step, TARGET), computed at 6-bit width so no wrap-around occurs; every other count SHALL be unchanged unless CAPTURE_EN applies.
REQ-017 If the new cnt[T] equals TARGET, UPDATE SHALL go to DONE with winner = T and done = 1, and T SHALL NOT advance.
REQ-018 Otherwise ADVANCE SHALL set T = T + 1, wrapping to 0 after the last active player (index 1, 2 or 3 for the latched N).
REQ-019 Latency SHALL be: handshake edge, then the count updated one edge later, then T advanced one edge after that, then step_ready high again in the following cycle.
REQ-020 A step of 0 SHALL still pass through UPDATE and ADVANCE, so the turn passes to the next player.
REQ-021 Counts of inactive players SHALL remain 0 for the whole game.
REQ-022 A start pulse in WAIT_STEP, UPDATE or ADVANCE SHALL be ignored; step_valid outside WAIT_STEP SHALL be ignored.
REQ-023 In DONE the counts, winner and T SHALL hold until start or rst.

Reset
REQ-024 rst SHALL force, asynchronously: state = IDLE, T = 0, all counts = 0, done = 0, winner = 0, step_ready = 0, latched N = 00.
REQ-025 rst asserted in the middle of a game SHALL discard any step in flight, and no partial count update SHALL survive.

Configuration
REQ-026 Macro CAPTURE_EN: when defined, UPDATE SHALL also clear to 0 every other active player whose count equals the new cnt[T], provided that value is not 0 and not TARGET; the clears happen on the same edge as the mover's update.
REQ-027 When CAPTURE_EN is not defined, other players' counts SHALL never change during UPDATE.

Structure
REQ-028 A shared package SHALL hold: the FSM state encoding; the CNT_W = 5 width constant; the N code constants (2P = 00, 3P = 01, 4P = 10).
REQ-029 A sub-module player_turn_ctr SHALL hold T, its wrap-at-last-player logic and the latched N; the count registers and FSM stay at top level.

Verification
REQ-030 Reset with N = 00 (2 players), steps 3 then 5 -> p1_cnt = 3, p2_cnt = 5, T back to 0, p3_cnt and p4_cnt = 0.
REQ-031 4-player game, 4 steps of 2 -> T sequence 0, 1, 2, 3, 0; each count = 2.
REQ-032 p1_cnt = 22 with TARGET = 24, step 7 -> p1_cnt = 24, done = 1, winner = 0, step_ready = 0, T = 0.
REQ-033 CAPTURE_EN defined, p2_cnt = 6, p1 at 4 steps 2 -> p1_cnt = 6, p2_cnt = 0; same stimulus without the macro -> p2_cnt stays 6.
REQ-034 rst asserted the cycle after a step handshake -> all counts = 0, T = 0, state IDLE, step_ready = 0; start accepted on the next pulse.
REQ-035 Step 0 offered to player 2 of 3 -> p2_cnt unchanged, T advances 1 -> 2; start pulse during UPDATE -> ignored.
